dots_display: RTL
=================

# dots_display

Downstream stage of the number-to-bitmap decoder (`dots`). It takes a parallel column bitmap of `CHARS` 5x8 characters and serially shifts it into the labkit's HCMS-style alphanumeric LED display. After reset it initialises the display: it pulses the display reset, loads control word 0 and unblanks. From then on it re-sends the bitmap on each `update` request. It owns all display strobes (`disp_*`) and exposes a single `busy` status to the surrounding lab logic.

## Interface
- `CHARS`, 2: number of characters driven; bitmap width N = 40*CHARS.
- `CLK_DIV`, 4: `clk` cycles per `disp_clock` half-period (≥1).
- `RST_CYCLES`, 16: `clk` cycles `disp_reset_b` is held low after `reset`.
- `CTRL_WORD`, 8'h7F: control word 0 (normal mode, max peak current, max brightness).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dots_in`  in  N  bitmap, 8 bits per column, 5 columns per char; bit N-1 is the leftmost column MSB.
- `update`  in  1  request to send `dots_in` to the display.
- `busy`  out  1  high while initialising or shifting.
- `disp_blank`  out  1  display blank (1 = blanked).
- `disp_clock`  out  1  display serial clock; data is sampled by the display on its rising edge.
- `disp_data_out`  out  1  serial data.
- `disp_rs`  out  1  register select: 1 = control, 0 = dot.
- `disp_ce_b`  out  1  chip enable, active low; its rising edge latches the shifted word.
- `disp_reset_b`  out  1  display reset, active low.

## Operation
- States: RST_DISP → CTRL_SHIFT → CTRL_LATCH → LOAD → DOT_SHIFT → DOT_LATCH → IDLE; from IDLE, `update` or pending → LOAD.
- **RST_DISP:** `disp_reset_b`=0 for RST_CYCLES cycles, then 1.
- **CTRL_SHIFT:** `disp_rs`=1, `disp_ce_b`=0, shift CTRL_WORD MSB first (8 bits).
- **CTRL_LATCH:** `disp_ce_b`→1. `disp_blank`→0 on the transition into LOAD.
- **LOAD:**
  - Captures `dots_in` into an internal shift register (one cycle).
  - Clears the pending flag.
  - The first LOAD after init is automatic; no `update` is needed.
- **DOT_SHIFT:** `disp_rs`=0, `disp_ce_b`=0, shift N bits, bit N-1 first.
- **DOT_LATCH:** `disp_ce_b`→1, hold one half-period, then go to IDLE.
- **`update` handling:**
  - `update` high in IDLE: captured that same edge, i.e. behaves as LOAD, then DOT_SHIFT.
  - `update` high while `busy`: sets the pending flag. Multiple requests collapse to one.
  - A pending request is serviced immediately after the current frame, using `dots_in` sampled at that later LOAD.
- `dots_in` is sampled only at LOAD; changes during shifting do not affect the frame in flight.
- `busy`=1 in every state except IDLE.
- **Reset values:**
  - `busy`=1, `disp_blank`=1, `disp_reset_b`=0, `disp_ce_b`=1.
  - `disp_clock`=0, `disp_rs`=0, `disp_data_out`=0.
  - Pending flag cleared, state RST_DISP.
- **Reset mid-frame:** abort immediately to reset values. The partial word is never latched, because `disp_ce_b` goes high only with `disp_reset_b` low. The full init sequence then repeats.

## Timing
- **Bit cell:** `disp_clock` low for CLK_DIV cycles, then high for CLK_DIV cycles.
- `disp_data_out` changes only at the start of a low phase, giving CLK_DIV cycles of setup and hold around the rising edge.
- `disp_rs` and `disp_ce_b` fall together at the start of the first bit cell's low phase.
- **Latch:**
  - After the last high phase, `disp_clock` returns low.
  - `disp_ce_b` rises CLK_DIV cycles later.
  - `disp_clock` stays 0 while `disp_ce_b`=1.
- **Frame latency:**
  - `update` accepted in IDLE at edge k gives `busy`=1 from edge k through edge k + 2·CLK_DIV·(N+1), then 0.
  - Defaults: 648 cycles.
- **Init length:** RST_CYCLES + 2·CLK_DIV·9 cycles, followed by the first frame.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset sequence (defaults):**
  - `reset` pulsed for 1 cycle.
  - `disp_reset_b` low for 16 cycles.
  - Then exactly 8 `disp_clock` rising edges with `disp_rs`=1 and sampled data 0x7F.
  - `disp_ce_b` rises with clock low; then `disp_blank`=0.
- **Digit frame:** `dots_in` = ' 7' pattern (upper 40 bits zero, lower 40 = 0x01_71_09_05_03).
  - Capture the bits sampled on the 80 rising edges with `disp_rs`=0; they must equal `dots_in` MSB first.
  - `busy` must fall exactly 648 cycles after acceptance.
- **Update while busy:**
  - Pulse `update` 3 times during a frame, changing `dots_in` to '15' before the frame ends.
  - Exactly one extra frame follows, carrying the '15' bitmap; then IDLE.
- **Input stability:** toggle `dots_in` every cycle during DOT_SHIFT. The shifted frame must still equal the value captured at LOAD.
- **Mid-frame reset:**
  - Assert `reset` at bit 40 of a frame.
  - Next cycle: `disp_reset_b`=0, `disp_ce_b`=1, `disp_blank`=1, `busy`=1.
  - No `disp_ce_b` rising edge while `disp_reset_b`=1 before the new init; full init replays.
- **Parameter corner (CLK_DIV=1, CHARS=1):**
  - Bit cell is 2 cycles and the frame is 40 bits.
  - `busy` lasts 82 cycles; data is stable across every rising edge.

Source files
------------

// File: rtl/dots_display.sv
// rtl/dots_display.sv - serialises a CHARS x 5x8 column bitmap into an HCMS-style LED display
// Runs the display init (reset pulse, control word 0, unblank), then re-sends the bitmap on each update.
module dots_display #(
  parameter int         CHARS      = 2,
  parameter int         CLK_DIV    = 4,
  parameter int         RST_CYCLES = 16,
  parameter logic [7:0] CTRL_WORD  = 8'h7F
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [40*CHARS-1:0] dots_in,
  input  logic                update,
  output logic                busy,
  output logic                disp_blank,
  output logic                disp_clock,
  output logic                disp_data_out,
  output logic                disp_rs,
  output logic                disp_ce_b,
  output logic                disp_reset_b
);

  localparam int N       = 40 * CHARS;
  localparam int CNT_MAX = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(N);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(N - 1);

  typedef enum logic [2:0] {
    RST_DISP, CTRL_SHIFT, CTRL_LATCH, LOAD, DOT_SHIFT, DOT_LATCH, IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          blank_q, blank_d;
  logic          clock_q, clock_d;
  logic          data_q, data_d;
  logic          rs_q, rs_d;
  logic          ce_b_q, ce_b_d;
  logic          reset_b_q, reset_b_d;
  logic          start_frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    pending_d   = pending_q | update;
    blank_d     = blank_q;
    clock_d     = clock_q;
    data_d      = data_q;
    rs_d        = rs_q;
    ce_b_d      = ce_b_q;
    reset_b_d   = reset_b_q;
    start_frame = (state_q == LOAD) || ((state_q == IDLE) && (update || pending_q));

    case (state_q)
      RST_DISP: begin
        if (cnt_q == RST_LAST) begin
          state_d   = CTRL_SHIFT;
          cnt_d     = '0;
          bit_d     = BW'(7);
          reset_b_d = 1'b1;
          rs_d      = 1'b1;
          ce_b_d    = 1'b0;
          clock_d   = 1'b0;
          data_d    = CTRL_WORD[7];
          shreg_d   = {CTRL_WORD[6:0], {(N-7){1'b0}}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A bit cell ends on the last cycle of its high phase; data only moves then.
      CTRL_SHIFT, DOT_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!clock_q) begin
            clock_d = 1'b1;
          end else begin
            clock_d = 1'b0;
            if (bit_q == '0) begin
              state_d = (state_q == CTRL_SHIFT) ? CTRL_LATCH : DOT_LATCH;
            end else begin
              bit_d   = bit_q - BW'(1);
              data_d  = shreg_q[N-1];
              shreg_d = {shreg_q[N-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // First half-period: clock low with ce_b still low; second: ce_b high, then leave.
      CTRL_LATCH, DOT_LATCH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!ce_b_q) begin
            ce_b_d = 1'b1;
          end else if (state_q == CTRL_LATCH) begin
            state_d = LOAD;
            blank_d = 1'b0;
          end else begin
            state_d = (pending_q || update) ? LOAD : IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD, IDLE: ;
      default: state_d = RST_DISP;
    endcase

    if (start_frame) begin
      state_d   = DOT_SHIFT;
      cnt_d     = '0;
      bit_d     = BIT_TOP;
      pending_d = 1'b0;
      rs_d      = 1'b0;
      ce_b_d    = 1'b0;
      clock_d   = 1'b0;
      data_d    = dots_in[N-1];
      shreg_d   = {dots_in[N-2:0], 1'b0};
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_DISP;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      blank_q   <= 1'b1;
      clock_q   <= 1'b0;
      data_q    <= 1'b0;
      rs_q      <= 1'b0;
      ce_b_q    <= 1'b1;
      reset_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      blank_q   <= blank_d;
      clock_q   <= clock_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      ce_b_q    <= ce_b_d;
      reset_b_q <= reset_b_d;
    end
  end

  assign busy          = busy_q;
  assign disp_blank    = blank_q;
  assign disp_clock    = clock_q;
  assign disp_data_out = data_q;
  assign disp_rs       = rs_q;
  assign disp_ce_b     = ce_b_q;
  assign disp_reset_b  = reset_b_q;

endmodule
